data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
Shares the single-port data_memory between two requesters: port 0 is the CPU load/store stage and port 1 is a debug/DMA loader. It accepts one request at a time through a valid/ready handshake and drives the memory's address, data and read/write strobes for exactly one cycle. It returns read data or a write acknowledge through a one-cycle response pulse. It sits directly in front of data_memory and is the only block that drives that memory's inputs.

Parameters:
ADDR_WIDTH, 32, byte address width passed through to memory address_i
DATA_WIDTH, 32, word width of write data and read data

Ports:
clock_i  in  1  single clock, rising edge
reset_i  in  1  asynchronous, active-high reset
req0_valid_i  in  1  port 0 request pending
req0_write_i  in  1  port 0: 1 = write, 0 = read
req0_address_i  in  ADDR_WIDTH  port 0 byte address
req0_data_i  in  DATA_WIDTH  port 0 write data
req0_ready_o  out  1  port 0 request accepted this cycle
resp0_valid_o  out  1  port 0 response pulse
resp0_data_o  out  DATA_WIDTH  port 0 read data
req1_* / resp1_*  same set as port 0, for port 1
mem_address_o  out  ADDR_WIDTH  to memory address_i
mem_data_o  out  DATA_WIDTH  to memory data_i
mem_write_data_o  out  1  to memory write_data_i
mem_read_data_o  out  1  to memory read_data_i
mem_read_data_i  in  DATA_WIDTH  from memory read_data_o

Behaviour:
- Clock and reset: clock_i is the only clock. reset_i is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - All ready, resp_valid and mem strobe outputs = 0.
  - mem_address_o, mem_data_o and resp*_data_o = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any reqN_valid_i is high, select a winner and assert reqN_ready_o combinationally for that port only, in the same cycle.
  - On the clock edge, latch the winner's write, address and data, record grant = N, set last_grant = N, and go to ISSUE.
  - With no valid request, stay in IDLE.
- Arbitration:
  - Round-robin. If both ports are valid, the port != last_grant wins.
  - If one port is valid, that port wins regardless of last_grant.
- ISSUE (exactly 1 cycle):
  - mem_address_o and mem_data_o carry the latched values.
  - Exactly one of mem_write_data_o / mem_read_data_o is 1, according to the latched write bit; never both.
  - The memory acts on the rising edge that ends ISSUE. Next state is RESP.
- RESP (exactly 1 cycle):
  - Strobes are 0. The address is held stable.
  - respG_valid_o = 1 for the granted port only.
  - For a read, respG_data_o = mem_read_data_i. For a write, respG_data_o = 0 (acknowledge only).
  - Next state is IDLE.
- Timing:
  - Latency from accept to response is 2 cycles.
  - Maximum throughput is 1 transaction per 3 cycles.
  - ready is never asserted outside IDLE.
- Requester rules:
  - A requester must hold valid, write, address and data stable until it sees ready.
  - A request whose valid drops before ready is simply not served.
- Response data: resp*_data_o holds its last value between pulses. Consumers must qualify it with resp*_valid_o.
- Address handling: the address is passed unmodified. Word alignment is the requester's responsibility.
- Reset mid-operation: an in-flight transaction is dropped with no response and no further memory strobe. A strobe already on the wire is removed asynchronously.

Optional Feature:
DM_ARB_FIXED_PRIO_EN:
- Defined: fixed priority. Port 0 always wins when both ports are valid. last_grant is still updated but ignored.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then port 0 read of addr 0x8 (memory word 2 = 0x2) -> ready0 in accept cycle; mem_read_data_o=1 and mem_address_o=0x8 one cycle later; resp0_valid_o=1 with resp0_data_o=0x2 two cycles after accept; resp1_valid_o stays 0.
2. Port 1 write of 0x55 to addr 0xC, then port 1 read of 0xC -> mem_write_data_o pulses once with mem_data_o=0x55; write resp1_data_o=0; subsequent read returns 0x55.
3. Both ports valid continuously, each doing 4 reads -> grants alternate 0,1,0,1,0,1,0,1 starting with port 0; accepts 3 cycles apart; all responses go to the correct port.
4. With DM_ARB_FIXED_PRIO_EN, repeat scenario 3 -> port 0 takes all 4 grants first, then port 1 gets 4.
5. Assert reset_i during ISSUE of a write of 0xAA to 0x4 -> strobes drop immediately; no resp pulse; after release state is IDLE and port 0 wins the next tie.
6. Port 0 valid for 1 cycle while ISSUE is busy with port 1, then valid drops -> port 0 is never granted and no resp0_valid_o is produced.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port valid/ready arbiter in front of the single-port data_memory: port 0 = CPU, port 1 = debug/DMA.
// Round-robin by default; define DM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_write_i,
  input  logic [ADDR_WIDTH-1:0] req0_address_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  output logic                  resp0_valid_o,
  output logic [DATA_WIDTH-1:0] resp0_data_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_write_i,
  input  logic [ADDR_WIDTH-1:0] req1_address_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  resp1_valid_o,
  output logic [DATA_WIDTH-1:0] resp1_data_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_data_o,
  output logic                  mem_read_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d;
  logic [DATA_WIDTH-1:0] resp1_data_q, resp1_data_d;

  logic                  winner;
  logic                  ready0, ready1;
  logic [DATA_WIDTH-1:0] resp_payload;

  // Winner is only meaningful when at least one port is valid.
  always_comb begin
`ifdef DM_ARB_FIXED_PRIO_EN
    winner = ~req0_valid_i;
`else
    if (req0_valid_i && req1_valid_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~req0_valid_i;
    end
`endif
  end

  // NOTE: every _d signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          ready0       = ~winner;
          ready1       = winner;
          grant_d      = winner;
          last_grant_d = winner;
          write_d      = winner ? req1_write_i   : req0_write_i;
          addr_d       = winner ? req1_address_i : req0_address_i;
          data_d       = winner ? req1_data_i    : req0_data_i;
          state_d      = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes are acknowledged with zero data; the last payload is held between pulses.
  always_comb begin
    resp_payload  = write_q ? '0 : mem_read_data_i;
    resp0_valid_o = (state_q == RESP) && !grant_q;
    resp1_valid_o = (state_q == RESP) &&  grant_q;
    resp0_data_d  = resp0_valid_o ? resp_payload : resp0_data_q;
    resp1_data_d  = resp1_valid_o ? resp_payload : resp1_data_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp0_data_q <= '0;
      resp1_data_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp0_data_q <= resp0_data_d;
      resp1_data_q <= resp1_data_d;
    end
  end

  // Strobes decode straight from the async-reset state, so reset removes them without waiting for a clock.
  assign mem_write_data_o = (state_q == ISSUE) &&  write_q;
  assign mem_read_data_o  = (state_q == ISSUE) && !write_q;
  assign mem_address_o    = addr_q;
  assign mem_data_o       = data_q;
  assign req0_ready_o     = ready0 & ~reset_i;
  assign req1_ready_o     = ready1 & ~reset_i;
  assign resp0_data_o     = resp0_data_d;
  assign resp1_data_o     = resp1_data_d;

  a_strobe_exclusive : assert property (@(posedge clock_i) disable iff (reset_i)
    !(mem_write_data_o && mem_read_data_o));
  a_ready_onehot : assert property (@(posedge clock_i) disable iff (reset_i)
    $onehot0({req0_ready_o, req1_ready_o}));
  a_ready_idle_only : assert property (@(posedge clock_i) disable iff (reset_i)
    (req0_ready_o || req1_ready_o) |-> (state_q == IDLE));
  a_last_grant_tracks : assert property (@(posedge clock_i) disable iff (reset_i)
    (state_q == ISSUE) |-> (last_grant_q == grant_q));

endmodule
